// File: rtl/key_event_player.sv
// Key-event source for the Spectrum matrix decoder: live PS/2 toggle events merged
// with a host-loaded FIFO of scripted events replayed at a fixed slot interval.
module key_event_player #(
    parameter int DEPTH      = 32,
    parameter int DELAY      = 7000000,
    parameter bit LIVE_ABORT = 1'b1
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic [10:0]                ps2_key,
    input  logic                       wr,
    input  logic [9:0]                 wr_data,
    input  logic                       start,
    input  logic                       abort,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       busy,
    output logic                       overflow,
    output logic                       ev_strobe,
    output logic                       ev_release,
    output logic                       ev_extended,
    output logic [7:0]                 ev_code
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(DELAY + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           state;
    logic [9:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             primed;
    logic             old_toggle;
    logic             pend_valid;
    logic [9:0]       pend_data;

    logic             live_ev;
    logic             live_down;
    logic             at_slot;
    logic             pop;
    logic             pop_ev;
    logic             flush;
    logic             wr_ok;
    logic [9:0]       head;
    logic [LVL_W-1:0] level_nx;
    logic             ev_nx_valid;
    logic [9:0]       ev_nx;

    always_comb begin
        live_ev   = primed && (ps2_key[10] != old_toggle);
        live_down = live_ev && ps2_key[9];
        head      = mem[rd_ptr];
        at_slot   = (state == S_WAIT) && (count == CNT_W'(DELAY - 1));
        // A held scripted event blocks the next pop; the counter parks on the slot until it drains.
        pop       = at_slot && !pend_valid && (level != '0);
        pop_ev    = pop && (head != '0);
        flush     = abort || (LIVE_ABORT && live_down && (state == S_WAIT));
        wr_ok     = wr && (!full || pop);
        level_nx  = level - LVL_W'(pop) + LVL_W'(wr_ok);

        ev_nx_valid = 1'b0;
        ev_nx       = '0;
        if (live_ev) begin
            ev_nx_valid = 1'b1;
            ev_nx       = {~ps2_key[9], ps2_key[8], ps2_key[7:0]};
        end else if (!flush && pend_valid) begin
            ev_nx_valid = 1'b1;
            ev_nx       = pend_data;
        end else if (!flush && pop_ev) begin
            ev_nx_valid = 1'b1;
            ev_nx       = head;
        end
    end

    assign busy = (state == S_WAIT);

    always_ff @(posedge clk_sys) begin
        if (wr_ok && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            full        <= 1'b0;
            overflow    <= 1'b0;
            count       <= '0;
            primed      <= 1'b0;
            old_toggle  <= 1'b0;
            pend_valid  <= 1'b0;
            pend_data   <= '0;
            ev_strobe   <= 1'b0;
            ev_release  <= 1'b0;
            ev_extended <= 1'b0;
            ev_code     <= '0;
        end else begin
            if (!primed) begin
                primed     <= 1'b1;
                old_toggle <= ps2_key[10];
            end else if (live_ev) begin
                old_toggle <= ps2_key[10];
            end

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                level  <= '0;
                full   <= 1'b0;
            end else begin
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                level <= level_nx;
                full  <= (level_nx == LVL_W'(DEPTH));
            end

            if (wr && !wr_ok) begin
                overflow <= 1'b1;
            end else if (start && !abort && (state == S_IDLE)) begin
                overflow <= 1'b0;
            end

            ev_strobe <= ev_nx_valid;
            if (ev_nx_valid) begin
                {ev_release, ev_extended, ev_code} <= ev_nx;
            end

            if (flush) begin
                pend_valid <= 1'b0;
            end else if (live_ev && pop_ev) begin
                pend_valid <= 1'b1;
                pend_data  <= head;
            end else if (!live_ev) begin
                pend_valid <= 1'b0;
            end

            if (flush) begin
                state <= S_IDLE;
                count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && (level != '0)) begin
                            state <= S_WAIT;
                            count <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (pop) begin
                            count <= '0;
                            if (level_nx == '0) state <= S_IDLE;
                        end else if (!at_slot) begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_event_player.sv
// Directed bench for key_event_player: two instances (abort-on-live-key on and off)
// share stimulus; expected events are queued with their cycle and checked on arrival.
module tb_key_event_player;

    localparam int DEPTH = 4;
    localparam int DELAY = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef struct {
        int         cyc;
        logic       rel;
        logic       ext;
        logic [7:0] code;
    } ev_t;

    logic             clk_sys = 1'b0;
    logic             reset;
    logic [10:0]      ps2_key;
    logic             wr;
    logic [9:0]       wr_data;
    logic             start;
    logic             abort;

    logic             a_full, a_busy, a_ovf, a_strobe, a_rel, a_ext;
    logic [LVL_W-1:0] a_level;
    logic [7:0]       a_code;
    logic             b_full, b_busy, b_ovf, b_strobe, b_rel, b_ext;
    logic [LVL_W-1:0] b_level;
    logic [7:0]       b_code;

    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    ev_t qa[$];
    ev_t qb[$];

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    key_event_player #(.DEPTH(DEPTH), .DELAY(DELAY), .LIVE_ABORT(1'b1)) dut_a (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .wr(wr), .wr_data(wr_data),
        .start(start), .abort(abort), .full(a_full), .level(a_level), .busy(a_busy),
        .overflow(a_ovf), .ev_strobe(a_strobe), .ev_release(a_rel), .ev_extended(a_ext),
        .ev_code(a_code)
    );

    key_event_player #(.DEPTH(DEPTH), .DELAY(DELAY), .LIVE_ABORT(1'b0)) dut_b (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .wr(wr), .wr_data(wr_data),
        .start(start), .abort(abort), .full(b_full), .level(b_level), .busy(b_busy),
        .overflow(b_ovf), .ev_strobe(b_strobe), .ev_release(b_rel), .ev_extended(b_ext),
        .ev_code(b_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_ev(input bit to_a, input bit to_b, input int c,
                             input logic rel, input logic ext, input logic [7:0] code);
        ev_t e;
        e = '{c, rel, ext, code};
        if (to_a) qa.push_back(e);
        if (to_b) qb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic push_wr(input logic [9:0] d);
        wr = 1'b1;
        wr_data = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic live(input logic pressed, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    endtask

    always @(negedge clk_sys) begin : mon_a
        ev_t e;
        if (a_strobe === 1'b1) begin
            if (qa.size() == 0) begin
                chk("A spurious strobe", a_strobe, 0);
            end else begin
                e = qa.pop_front();
                chk("A event cycle", cyc, e.cyc);
                chk("A event fields", {a_rel, a_ext, a_code}, {e.rel, e.ext, e.code});
            end
        end else if (qa.size() != 0 && qa[0].cyc < cyc) begin
            chk("A missing event cycle", cyc, qa[0].cyc);
            void'(qa.pop_front());
        end
    end

    always @(negedge clk_sys) begin : mon_b
        ev_t e;
        if (b_strobe === 1'b1) begin
            if (qb.size() == 0) begin
                chk("B spurious strobe", b_strobe, 0);
            end else begin
                e = qb.pop_front();
                chk("B event cycle", cyc, e.cyc);
                chk("B event fields", {b_rel, b_ext, b_code}, {e.rel, e.ext, e.code});
            end
        end else if (qb.size() != 0 && qb[0].cyc < cyc) begin
            chk("B missing event cycle", cyc, qb[0].cyc);
            void'(qb.pop_front());
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        reset   = 1'b1;
        ps2_key = 11'h400;
        wr      = 1'b0;
        wr_data = '0;
        start   = 1'b0;
        abort   = 1'b0;
        repeat (3) tick();
        chk("A reset outputs", {a_strobe, a_full, a_level, a_busy, a_ovf}, 0);
        chk("B reset outputs", {b_strobe, b_full, b_level, b_busy, b_ovf}, 0);

        // priming: toggle high at release must not produce an event
        reset = 1'b0;
        repeat (6) tick();
        s = cyc;
        ps2_key = {1'b0, 1'b1, 1'b0, 8'h1C};
        expect_ev(1, 1, s + 1, 1'b0, 1'b0, 8'h1C);
        repeat (3) tick();

        // basic playback with a pause slot
        push_wr(10'h059);
        push_wr(10'h000);
        push_wr(10'h259);
        chk("A level after 3 writes", a_level, 3);
        chk("B level after 3 writes", b_level, 3);
        s = cyc;
        expect_ev(1, 1, s + 5, 1'b0, 1'b0, 8'h59);
        expect_ev(1, 1, s + 13, 1'b1, 1'b0, 8'h59);
        pulse_start();
        chk("A busy after start", a_busy, 1);
        wait_until(s + 12);
        chk("A busy before last slot", a_busy, 1);
        tick();
        chk("A busy after last slot", a_busy, 0);
        chk("A level after playback", a_level, 0);
        chk("B busy after last slot", b_busy, 0);

        // overflow: fifth write dropped, start clears the flag
        for (int i = 0; i < 5; i++) push_wr(10'(8'h11 + i));
        chk("A full", a_full, 1);
        chk("A level full", a_level, 4);
        chk("A overflow set", a_ovf, 1);
        chk("B overflow set", b_ovf, 1);
        s = cyc;
        for (int i = 0; i < 4; i++) expect_ev(1, 1, s + 5 + 4 * i, 1'b0, 1'b0, 8'(8'h11 + i));
        pulse_start();
        chk("A overflow cleared", a_ovf, 0);
        chk("B overflow cleared", b_ovf, 0);
        wait_until(s + 17);
        chk("A busy after drain", a_busy, 0);
        chk("A full after drain", a_full, 0);
        tick();

        // live key-up collides with a scripted emit: live first, scripted held one cycle
        push_wr(10'h021);
        push_wr(10'h122);
        s = cyc;
        pulse_start();
        wait_until(s + 4);
        live(1'b0, 8'h44);
        expect_ev(1, 1, s + 5, 1'b1, 1'b0, 8'h44);
        expect_ev(1, 1, s + 6, 1'b0, 1'b0, 8'h21);
        expect_ev(1, 1, s + 9, 1'b0, 1'b1, 8'h22);
        wait_until(s + 9);
        chk("A busy after collision run", a_busy, 0);
        chk("B busy after collision run", b_busy, 0);
        tick();

        // live key-down mid-playback: A flushes, B keeps playing
        push_wr(10'h031);
        push_wr(10'h032);
        push_wr(10'h033);
        s = cyc;
        expect_ev(1, 1, s + 5, 1'b0, 1'b0, 8'h31);
        pulse_start();
        wait_until(s + 6);
        live(1'b1, 8'h55);
        expect_ev(1, 1, s + 7, 1'b0, 1'b0, 8'h55);
        expect_ev(0, 1, s + 9, 1'b0, 1'b0, 8'h32);
        expect_ev(0, 1, s + 13, 1'b0, 1'b0, 8'h33);
        tick();
        chk("A busy after live abort", a_busy, 0);
        chk("A level after live abort", a_level, 0);
        chk("B busy after live key-down", b_busy, 1);
        chk("B level after live key-down", b_level, 2);
        wait_until(s + 13);
        chk("B busy after drain", b_busy, 0);
        tick();

        // live key-up mid-playback never aborts
        push_wr(10'h031);
        push_wr(10'h032);
        push_wr(10'h033);
        s = cyc;
        expect_ev(1, 1, s + 5, 1'b0, 1'b0, 8'h31);
        pulse_start();
        wait_until(s + 6);
        live(1'b0, 8'h55);
        expect_ev(1, 1, s + 7, 1'b1, 1'b0, 8'h55);
        expect_ev(1, 1, s + 9, 1'b0, 1'b0, 8'h32);
        expect_ev(1, 1, s + 13, 1'b0, 1'b0, 8'h33);
        tick();
        chk("A busy after live key-up", a_busy, 1);
        chk("A level after live key-up", a_level, 2);
        wait_until(s + 13);
        chk("A busy after key-up run", a_busy, 0);
        tick();

        // abort beats start, abort discards a same-cycle write, start on empty is ignored
        push_wr(10'h041);
        push_wr(10'h042);
        chk("A level before abort", a_level, 2);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("A busy after abort+start", a_busy, 0);
        chk("A level after abort+start", a_level, 0);
        chk("B busy after abort+start", b_busy, 0);
        chk("B level after abort+start", b_level, 0);
        push_wr(10'h043);
        chk("A level before abort+wr", a_level, 1);
        abort   = 1'b1;
        wr      = 1'b1;
        wr_data = 10'h077;
        tick();
        abort = 1'b0;
        wr    = 1'b0;
        chk("A level after abort+wr", a_level, 0);
        chk("B level after abort+wr", b_level, 0);
        pulse_start();
        chk("A busy after empty start", a_busy, 0);

        // asynchronous reset in the middle of a wait slot
        push_wr(10'h051);
        push_wr(10'h052);
        pulse_start();
        tick();
        chk("A busy before reset", a_busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("A outputs on async reset",
            {a_strobe, a_rel, a_ext, a_code, a_full, a_level, a_busy, a_ovf}, 0);
        chk("B outputs on async reset",
            {b_strobe, b_rel, b_ext, b_code, b_full, b_level, b_busy, b_ovf}, 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (6) tick();
        chk("A expected queue drained", qa.size(), 0);
        chk("B expected queue drained", qb.size(), 0);
        chk("A idle after reset", a_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_event_player.md
Name: key_event_player

Overview:
- Parametrised key-event source that feeds the Spectrum matrix decoder.
- Merges live PS/2 events (toggle protocol on ps2_key) with a host-loaded FIFO of scripted key events.
- Scripted events are replayed with a programmable inter-event delay.
- Generalises the fixed F10 autotype sequence: depth, delay and abort-on-live-key are parameters, and the queue can be refilled during playback.

Parameters:
- DEPTH, 32, queue entries (power of two, >=2).
- DELAY, 7000000, clk_sys cycles between scripted slots (>=1).
- LIVE_ABORT, 1, 1 = any live key-down during playback flushes the queue.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scancode
- wr  in  1  enqueue wr_data this cycle
- wr_data  in  10  [9] release, [8] extended, [7:0] code; all-zero = pause slot
- start  in  1  begin playback (pulse)
- abort  in  1  flush queue, stop playback (pulse)
- full  out  1  queue holds DEPTH entries
- level  out  $clog2(DEPTH+1)  entries queued
- busy  out  1  playback active
- overflow  out  1  sticky: write attempted while full
- ev_strobe  out  1  one-cycle event valid
- ev_release  out  1  event is key-up
- ev_extended  out  1  E0-prefixed
- ev_code  out  8  scancode

Behaviour:
- Reset (async) values:
  - all outputs 0; level 0; queue pointers 0.
  - state IDLE, delay counter 0, primed 0, pending 0.
- Toggle priming: first clk_sys edge after reset release loads old_toggle <= ps2_key[10] and sets primed; no event is emitted on that edge.
- Live path:
  - at an edge with primed=1 and ps2_key[10] != old_toggle, update old_toggle.
  - register ev_strobe=1, ev_release=~ps2_key[9], ev_extended=ps2_key[8], ev_code=ps2_key[7:0].
  - Latency: one edge.
- Queue: circular FIFO.
  - wr while full: dropped, overflow <= 1.
  - wr and pop in the same cycle with level=DEPTH: write accepted (level unchanged).
  - wr when empty and not popping: level+1.
- FSM:
  - IDLE: busy=0. start with level>0 -> WAIT, counter=0. start with level=0 is ignored. start also clears overflow.
  - WAIT: busy=1, counter increments. At counter==DELAY-1: pop head, counter=0.
    - Non-pause entry -> emit (see arbitration).
    - Pause entry -> no event.
    - If the queue is empty after the pop -> IDLE; otherwise stay in WAIT.
- Arbitration:
  - live event and scripted emit in the same cycle: live wins; the scripted event is held in a 1-entry pending register and emitted next cycle.
  - The delay counter keeps running during pending; pending drains before the next pop is possible.
- LIVE_ABORT=1:
  - a live key-down while busy flushes the queue (level=0, pointers equal) and moves to IDLE.
  - The live event itself is still emitted; any pending scripted event is discarded.
  - Live key-ups never abort.
- abort:
  - flushes the queue and pending, goes to IDLE, counter=0.
  - abort+start in the same cycle: abort wins.
  - abort+wr in the same cycle: queue ends empty (write discarded).
- Outputs are registered; ev_* fields hold their last value when ev_strobe=0.
- Reset mid-playback: immediate IDLE, queue empty, no strobe until a new toggle after priming.

Test Plan:
- Reset with ps2_key[10]=1, release, hold for 5 cycles -> no ev_strobe. Then toggle to 0 with code 8'h1C pressed -> exactly one ev_strobe, ev_release=0, ev_code=8'h1C, one edge after the change.
- DELAY=4. Write 059, 000, 259; start -> strobes at cycles 4 and 12 after start (code 59, release 0 then 1); busy falls at cycle 12; level 0.
- DEPTH=4. Write 5 entries -> full=1, level=4, overflow=1. start -> overflow=0.
- Live toggle on the same cycle as a scripted emit (LIVE_ABORT=0) -> live event at N, scripted event at N+1, nothing lost.
- LIVE_ABORT=1. Playback of 3 entries; live key-down after the first emit -> live strobe emitted, busy=0, level=0, no further scripted strobes. Repeat with a live key-up -> playback continues.
- abort and start asserted together with level=2 -> busy stays 0, level=0. Assert reset during WAIT -> all outputs 0 immediately.
